// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the multicycle MIPS-subset CPU.
// Holds the main-decoder state encoding, opcode and aluop constants, the
// datapath mux-select encodings, the control-word payload and opcode helpers.
// The ALU decoder imports the same aluop constants so both ends agree.
package mips_ctrl_pkg;

    localparam int unsigned OPW    = 6;  // opcode field width
    localparam int unsigned ALUOPW = 2;  // aluop width, shared with the ALU decoder
    localparam int unsigned STATEW = 4;  // main FSM state register width

    // Main control FSM states; encodings 12..15 are unused.
    typedef enum logic [STATEW-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BEQ      = 4'd8,
        ADDI_EX  = 4'd9,
        ADDI_WB  = 4'd10,
        JUMP     = 4'd11
    } state_t;

    // Supported opcodes (instr[31:26]).
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    // ALU operation class handed to the ALU decoder.
    localparam logic [ALUOPW-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOPW-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOPW-1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full control word driven onto the datapath each cycle.
    typedef struct packed {
        logic              iord;
        logic              irwrite;
        logic              memwrite;
        logic              mem_req;
        logic              regdst;
        logic              memtoreg;
        logic              regwrite;
        logic              alusrca;
        logic [1:0]        alusrcb;
        logic [ALUOPW-1:0] aluop;
        logic [1:0]        pcsrc;
        logic              pcwrite;
        logic              branch;
        logic              instr_done;
        logic              illegal_op;
    } ctrl_t;

    // True for every opcode the main decoder can sequence.
    function automatic logic op_legal(input logic [OPW-1:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    endfunction

    // State entered from DECODE; unsupported opcodes return straight to FETCH.
    function automatic state_t decode_target(input logic [OPW-1:0] op);
        case (op)
            OP_LW, OP_SW: decode_target = MEMADR;
            OP_RTYPE:     decode_target = RTYPE_EX;
            OP_BEQ:       decode_target = BEQ;
            OP_ADDI:      decode_target = ADDI_EX;
            OP_J:         decode_target = JUMP;
            default:      decode_target = FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_maindec.sv
// Multicycle main control FSM for the MIPS-subset CPU.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath enable and mux select as a Moore decode of state.
// Only the FETCH pcwrite/irwrite and the instr_done pulse look at mem_ready.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   op                  instr[31:26] from the instruction register
//   mem_ready           memory access completes this cycle
//   iord, irwrite       memory address select, instruction register load
//   memwrite, mem_req   data memory write strobe, memory access request
//   regdst, memtoreg    write-register select, writeback select
//   regwrite            register file write
//   alusrca, alusrcb    ALU operand selects
//   aluop               operation class for the ALU decoder
//   pcsrc, pcwrite      next-PC select, unconditional PC load
//   branch              PC load qualified by zero
//   instr_done          pulse on the last cycle of each instruction
//   illegal_op          pulse in DECODE for an unsupported opcode
module multicycle_maindec
    import mips_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    op,
    input  logic              mem_ready,
    output logic              iord,
    output logic              irwrite,
    output logic              memwrite,
    output logic              mem_req,
    output logic              regdst,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [ALUOPW-1:0] aluop,
    output logic [1:0]        pcsrc,
    output logic              pcwrite,
    output logic              branch,
    output logic              instr_done,
    output logic              illegal_op
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; op only matters in DECODE and MEMADR.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:    if (mem_ready) state_next = DECODE;
            DECODE:   state_next = decode_target(op);
            MEMADR:   state_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    if (mem_ready) state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWR:    if (mem_ready) state_next = FETCH;
            RTYPE_EX: state_next = RTYPE_WB;
            RTYPE_WB: state_next = FETCH;
            BEQ:      state_next = FETCH;
            ADDI_EX:  state_next = ADDI_WB;
            ADDI_WB:  state_next = FETCH;
            JUMP:     state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    // Control word decode; reset overrides everything so no strobe leaks
    // out while the state register is being forced.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b0;
                ctrl.alusrca = 1'b0;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut.
                ctrl.alusrca = 1'b0;
                ctrl.alusrcb = SRCB_IMM_SH;
                ctrl.aluop   = ALUOP_ADD;
                if (!op_legal(op)) begin
                    ctrl.illegal_op = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.regdst     = 1'b0;
                ctrl.memtoreg   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                // Write strobe held through every wait cycle.
                ctrl.mem_req    = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            RTYPE_EX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_RT;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPE_WB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.regdst     = 1'b1;
                ctrl.memtoreg   = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            BEQ: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_RT;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ADDI_EX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            ADDI_WB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.regdst     = 1'b0;
                ctrl.memtoreg   = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            JUMP: begin
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
        if (reset) begin
            ctrl = '0;
        end
    end

    assign iord       = ctrl.iord;
    assign irwrite    = ctrl.irwrite;
    assign memwrite   = ctrl.memwrite;
    assign mem_req    = ctrl.mem_req;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign regwrite   = ctrl.regwrite;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign aluop      = ctrl.aluop;
    assign pcsrc      = ctrl.pcsrc;
    assign pcwrite    = ctrl.pcwrite;
    assign branch     = ctrl.branch;
    assign instr_done = ctrl.instr_done;
    assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Directed self-checking bench for multicycle_maindec.
// All outputs are packed into one vector and compared against hand-built
// expected control words, one per cycle, after the clock edge settles.
module tb_multicycle_maindec;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       iord, irwrite, memwrite, mem_req, regdst, memtoreg, regwrite;
    logic       alusrca, pcwrite, branch, instr_done, illegal_op;
    logic [1:0] alusrcb, aluop, pcsrc;

    int checks   = 0;
    int failures = 0;

    // Field masks of the observed vector.
    localparam logic [17:0] M_IORD  = 18'h20000;
    localparam logic [17:0] M_IRW   = 18'h10000;
    localparam logic [17:0] M_MEMW  = 18'h08000;
    localparam logic [17:0] M_MREQ  = 18'h04000;
    localparam logic [17:0] M_RDST  = 18'h02000;
    localparam logic [17:0] M_M2R   = 18'h01000;
    localparam logic [17:0] M_RW    = 18'h00800;
    localparam logic [17:0] M_SRCA  = 18'h00400;
    localparam logic [17:0] B_01    = 18'h00100;
    localparam logic [17:0] B_10    = 18'h00200;
    localparam logic [17:0] B_11    = 18'h00300;
    localparam logic [17:0] AOP_01  = 18'h00040;
    localparam logic [17:0] AOP_10  = 18'h00080;
    localparam logic [17:0] PC_01   = 18'h00010;
    localparam logic [17:0] PC_10   = 18'h00020;
    localparam logic [17:0] M_PCW   = 18'h00008;
    localparam logic [17:0] M_BR    = 18'h00004;
    localparam logic [17:0] M_DONE  = 18'h00002;
    localparam logic [17:0] M_ILL   = 18'h00001;

    // Expected control words per state.
    localparam logic [17:0] E_FETCH_R  = M_MREQ | B_01 | M_IRW | M_PCW;
    localparam logic [17:0] E_FETCH_W  = M_MREQ | B_01;
    localparam logic [17:0] E_DECODE   = B_11;
    localparam logic [17:0] E_DEC_ILL  = B_11 | M_ILL | M_DONE;
    localparam logic [17:0] E_MEMADR   = M_SRCA | B_10;
    localparam logic [17:0] E_MEMRD    = M_MREQ | M_IORD;
    localparam logic [17:0] E_MEMWB    = M_RW | M_M2R | M_DONE;
    localparam logic [17:0] E_MEMWR_W  = M_MREQ | M_IORD | M_MEMW;
    localparam logic [17:0] E_MEMWR_R  = M_MREQ | M_IORD | M_MEMW | M_DONE;
    localparam logic [17:0] E_RTYPE_EX = M_SRCA | AOP_10;
    localparam logic [17:0] E_RTYPE_WB = M_RW | M_RDST | M_DONE;
    localparam logic [17:0] E_BEQ      = M_SRCA | AOP_01 | PC_01 | M_BR | M_DONE;
    localparam logic [17:0] E_ADDI_EX  = M_SRCA | B_10;
    localparam logic [17:0] E_ADDI_WB  = M_RW | M_DONE;
    localparam logic [17:0] E_JUMP     = PC_10 | M_PCW | M_DONE;

    logic [17:0] obs;
    assign obs = {iord, irwrite, memwrite, mem_req, regdst, memtoreg, regwrite,
                  alusrca, alusrcb, aluop, pcsrc, pcwrite, branch, instr_done,
                  illegal_op};

    multicycle_maindec dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .mem_req    (mem_req),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .aluop      (aluop),
        .pcsrc      (pcsrc),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [17:0] o, input logic [17:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Advance one clock and let outputs settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        op        = OP_RTYPE;
        mem_ready = 1'b0;
        #1;
        chk("reset_outputs", obs, 18'h0);
        cyc();
        cyc();
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;

        // R-type; op change in RTYPE_EX must be ignored.
        chk("rt_fetch", obs, E_FETCH_R);
        cyc(); chk("rt_decode", obs, E_DECODE);
        cyc(); chk("rt_ex", obs, E_RTYPE_EX);
        op = OP_BEQ;
        cyc(); chk("rt_wb", obs, E_RTYPE_WB);
        cyc(); chk("rt_next_fetch", obs, E_FETCH_R);

        // Reset in the middle of an R-type execute.
        op = OP_RTYPE;
        cyc(); chk("rst_decode", obs, E_DECODE);
        cyc(); chk("rst_ex", obs, E_RTYPE_EX);
        reset = 1'b1;
        #1;
        chk("rst_async_outputs", obs, 18'h0);
        checks++;
        assert (dut.state === FETCH) else begin
            failures++;
            $error("FAIL rst_async_state observed=%0d expected=%0d", dut.state, FETCH);
        end
        cyc(); chk("rst_held", obs, 18'h0);
        reset = 1'b0;
        #1;
        chk("rst_release_fetch", obs, E_FETCH_R);

        // lw with two wait states in MEMRD.
        op = OP_LW;
        cyc(); chk("lw_decode", obs, E_DECODE);
        cyc(); chk("lw_memadr", obs, E_MEMADR);
        mem_ready = 1'b0;
        cyc(); chk("lw_memrd1", obs, E_MEMRD);
        cyc(); chk("lw_memrd2", obs, E_MEMRD);
        cyc();
        mem_ready = 1'b1;
        #1;
        chk("lw_memrd3", obs, E_MEMRD);
        cyc(); chk("lw_memwb", obs, E_MEMWB);
        cyc(); chk("lw_next_fetch", obs, E_FETCH_R);

        // Fetch wait state holds FETCH without loading PC/IR.
        mem_ready = 1'b0;
        #1;
        chk("fetch_wait1", obs, E_FETCH_W);
        cyc(); chk("fetch_wait2", obs, E_FETCH_W);
        mem_ready = 1'b1;
        #1;
        chk("fetch_ready", obs, E_FETCH_R);

        // sw, no wait states.
        op = OP_SW;
        cyc(); chk("sw_decode", obs, E_DECODE);
        cyc(); chk("sw_memadr", obs, E_MEMADR);
        cyc(); chk("sw_memwr", obs, E_MEMWR_R);
        cyc(); chk("sw_next_fetch", obs, E_FETCH_R);

        // sw with one wait state: memwrite held, done only when ready.
        cyc(); chk("sww_decode", obs, E_DECODE);
        mem_ready = 1'b0;
        cyc(); chk("sww_memadr", obs, E_MEMADR);
        cyc(); chk("sww_memwr_wait", obs, E_MEMWR_W);
        mem_ready = 1'b1;
        #1;
        chk("sww_memwr_ready", obs, E_MEMWR_R);
        cyc(); chk("sww_next_fetch", obs, E_FETCH_R);

        // beq
        op = OP_BEQ;
        cyc(); chk("beq_decode", obs, E_DECODE);
        cyc(); chk("beq_exec", obs, E_BEQ);
        cyc(); chk("beq_next_fetch", obs, E_FETCH_R);

        // j
        op = OP_J;
        cyc(); chk("j_decode", obs, E_DECODE);
        cyc(); chk("j_exec", obs, E_JUMP);
        cyc(); chk("j_next_fetch", obs, E_FETCH_R);

        // addi
        op = OP_ADDI;
        cyc(); chk("addi_decode", obs, E_DECODE);
        cyc(); chk("addi_ex", obs, E_ADDI_EX);
        cyc(); chk("addi_wb", obs, E_ADDI_WB);
        cyc(); chk("addi_next_fetch", obs, E_FETCH_R);

        // Illegal opcode: two-cycle instruction, no side effects.
        op = 6'b111111;
        cyc(); chk("ill_decode", obs, E_DEC_ILL);
        cyc(); chk("ill_next_fetch", obs, E_FETCH_R);
        cyc(); chk("ill_decode_again", obs, E_DEC_ILL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
